fir_decim_mac: RTL and testbench



---
 rtl/fir_decim_mac_if.sv | 31 +++
 rtl/fir_decim_mac.sv | 132 +++++++++++++
 tb/tb_fir_decim_mac.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_decim_mac_if.sv
// Sample, coefficient and output bus of the decimating FIR MAC.
// The master side feeds samples and coefficients, the slave side is the filter.
interface fir_decim_mac_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 32,
    parameter int OUT_W  = 16
);
    localparam int ADDR_W = $clog2(TAPS);

    logic                     clear;
    logic                     coef_we;
    logic [ADDR_W-1:0]        coef_addr;
    logic signed [COEF_W-1:0] coef_wdata;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic signed [OUT_W-1:0]  out_data;
    logic                     busy;

    modport master (
        output clear, coef_we, coef_addr, coef_wdata, in_valid, in_data,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  clear, coef_we, coef_addr, coef_wdata, in_valid, in_data,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/fir_decim_mac.sv
// Time-multiplexed FIR low-pass with integer decimation.
// One multiplier walks the circular sample history once per decimated output,
// then the accumulator is rounded half-up, shifted and saturated.
module fir_decim_mac #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 32,
    parameter int DECIM  = 1,
    parameter int SHIFT  = 15,
    parameter int OUT_W  = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    fir_decim_mac_if.slave   bus
);
    localparam int ADDR_W = $clog2(TAPS);
    localparam int DEC_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + ADDR_W;
    localparam int SAT_W  = (ACC_W + 1 > OUT_W) ? ACC_W + 2 : OUT_W + 1;

    localparam logic signed [SAT_W-1:0] RND =
        (SHIFT == 0) ? '0 : (SAT_W'(1) <<< ((SHIFT == 0) ? 0 : SHIFT - 1));
    localparam logic signed [SAT_W-1:0] OUT_MAX =
        {{(SAT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SAT_W-1:0] OUT_MIN =
        {{(SAT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                   state;
    state_t                   state_next;
    logic signed [COEF_W-1:0] coef [TAPS];
    logic signed [DATA_W-1:0] hist [TAPS];
    logic [ADDR_W-1:0]        wr_ptr;
    logic [ADDR_W-1:0]        rd_ptr;
    logic [ADDR_W-1:0]        k;
    logic [DEC_W-1:0]         dec_cnt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [PROD_W-1:0] product;
    logic signed [SAT_W-1:0]  rounded;
    logic signed [SAT_W-1:0]  shifted;
    logic signed [OUT_W-1:0]  sat_out;
    logic                     accept;
    logic                     trigger;
    logic                     last_tap;
    logic                     coef_in_range;

    assign accept        = (state == IDLE) && bus.in_valid && !bus.clear;
    assign trigger       = accept && (dec_cnt == DEC_W'(DECIM - 1));
    assign last_tap      = (k == ADDR_W'(TAPS - 1));
    assign coef_in_range = ({1'b0, bus.coef_addr} < (ADDR_W + 1)'(TAPS));

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state == MAC);
    assign bus.out_valid = (state == DONE);

    // State register; reset drops any run in flight.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state: one MAC pass of TAPS cycles per decimated sample, clear wins.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (trigger)  state_next = MAC;
            MAC:     if (last_tap) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (bus.clear) state_next = IDLE;
    end

    // Product, accumulate and the round/shift/saturate of the completed sum.
    always_comb begin
        product = coef[k] * hist[rd_ptr];
        acc_sum = acc + ACC_W'(product);
        rounded = SAT_W'(acc_sum) + RND;
        shifted = rounded >>> SHIFT;
        if (shifted > OUT_MAX)      sat_out = OUT_MAX[OUT_W-1:0];
        else if (shifted < OUT_MIN) sat_out = OUT_MIN[OUT_W-1:0];
        else                        sat_out = shifted[OUT_W-1:0];
    end

    // History, coefficients, pointers and accumulator; rd_ptr walks backwards
    // from the newest sample so tap k always meets x(n-k).
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            k            <= '0;
            dec_cnt      <= '0;
            acc          <= '0;
            bus.out_data <= '0;
            for (int i = 0; i < TAPS; i++) begin
                hist[i] <= '0;
                coef[i] <= '0;
            end
        end else if (bus.clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            k       <= '0;
            dec_cnt <= '0;
            acc     <= '0;
            for (int i = 0; i < TAPS; i++) hist[i] <= '0;
        end else begin
            if (state == IDLE && bus.coef_we && coef_in_range)
                coef[bus.coef_addr] <= bus.coef_wdata;
            if (accept) begin
                hist[wr_ptr] <= bus.in_data;
                wr_ptr <= (wr_ptr == ADDR_W'(TAPS - 1)) ? '0 : wr_ptr + ADDR_W'(1);
                if (trigger) begin
                    dec_cnt <= '0;
                    acc     <= '0;
                    k       <= '0;
                    rd_ptr  <= wr_ptr;
                end else begin
                    dec_cnt <= dec_cnt + DEC_W'(1);
                end
            end
            if (state == MAC) begin
                acc    <= acc_sum;
                k      <= last_tap ? '0 : k + ADDR_W'(1);
                rd_ptr <= (rd_ptr == '0) ? ADDR_W'(TAPS - 1) : rd_ptr - ADDR_W'(1);
                if (last_tap) bus.out_data <= sat_out;
            end
        end
    end
endmodule

// File: tb/tb_fir_decim_mac.sv
// Randomized bench for fir_decim_mac against a plain-arithmetic FIR model:
// newest-first sample queue, coefficient array and a decimation counter.
module tb_fir_decim_mac;
    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int TAPS   = 8;
    localparam int DECIM  = 3;
    localparam int SHIFT  = 12;
    localparam int OUT_W  = 16;
    localparam int ADDR_W = $clog2(TAPS);

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;

    fir_decim_mac_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W)) bus ();

    fir_decim_mac #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS),
        .DECIM(DECIM), .SHIFT(SHIFT), .OUT_W(OUT_W)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int     tests_run = 0;
    int     fails     = 0;
    int     cyc       = 0;
    int     trig_c    = -1000;
    int     dec_m     = 0;
    longint coef_m [TAPS];
    longint hist_m [$];
    longint exp_q [$];
    int     expc_q [$];
    longint last_out_m = 0;
    longint mon_exp;
    int     mon_c;
    bit     acc_flag;

    // Count one comparison and report it when it differs.
    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        tests_run++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    function automatic void clearHistory();
        hist_m = {};
        for (int i = 0; i < TAPS; i++) hist_m.push_back(0);
    endfunction

    // y = sum c[k]*x(n-k), round half-up, arithmetic shift, clamp to OUT_W.
    function automatic longint modelOut();
        longint s = 0;
        longint lim = longint'(1) << (OUT_W - 1);
        for (int i = 0; i < TAPS; i++) s += coef_m[i] * hist_m[i];
        if (SHIFT > 0) s += longint'(1) << (SHIFT - 1);
        s = s >>> SHIFT;
        if (s > lim - 1) s = lim - 1;
        if (s < -lim) s = -lim;
        return s;
    endfunction

    function automatic longint randData();
        if ($urandom_range(0, 3) == 0) return longint'($urandom_range(0, 65535)) - 32768;
        return longint'($urandom_range(0, 4000)) - 2000;
    endfunction

    // One clock cycle of stimulus; the model predicts handshake and state timing.
    task automatic applyStimulus(input bit valid, input longint data, input bit we,
                                 input int addr, input longint wdata, input bit clr,
                                 output bit accepted);
        bit in_mac, in_done, idle;
        in_mac  = (cyc >= trig_c) && (cyc < trig_c + TAPS);
        in_done = (cyc == trig_c + TAPS);
        idle    = !in_mac && !in_done;
        checkOutput("in_ready", longint'(bus.in_ready), longint'(idle));
        checkOutput("busy", longint'(bus.busy), longint'(in_mac));
        bus.in_valid   = valid;
        bus.in_data    = DATA_W'(data);
        bus.coef_we    = we;
        bus.coef_addr  = ADDR_W'(addr);
        bus.coef_wdata = COEF_W'(wdata);
        bus.clear      = clr;
        accepted = 1'b0;
        if (clr) begin
            if (in_mac) begin
                void'(exp_q.pop_back());
                void'(expc_q.pop_back());
            end
            trig_c = -1000;
            dec_m  = 0;
            clearHistory();
        end else if (idle) begin
            if (we && addr < TAPS) coef_m[addr] = wdata;
            if (valid) begin
                accepted = 1'b1;
                hist_m.push_front(data);
                void'(hist_m.pop_back());
                if (dec_m == DECIM - 1) begin
                    dec_m  = 0;
                    trig_c = cyc + 1;
                    exp_q.push_back(modelOut());
                    expc_q.push_back(cyc + 1);
                end else begin
                    dec_m++;
                end
            end
        end
        @(posedge sys_clk);
        cyc++;
        #1;
        bus.in_valid = 1'b0;
        bus.coef_we  = 1'b0;
        bus.clear    = 1'b0;
    endtask

    // Hold a sample (with an optional coefficient write) until it is accepted.
    task automatic sendSample(input longint data, input bit we, input int addr, input longint wdata);
        for (int i = 0; i < TAPS + 4; i++) begin
            applyStimulus(1'b1, data, we, addr, wdata, 1'b0, acc_flag);
            if (acc_flag) return;
        end
        checkOutput("handshake_timeout", 0, 1);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0, 0, 0, 1'b0, acc_flag);
    endtask

    task automatic writeCoef(input int addr, input longint wdata);
        applyStimulus(1'b0, 0, 1'b1, addr, wdata, 1'b0, acc_flag);
    endtask

    // Asynchronous reset: outputs must drop before any clock edge.
    task automatic doReset();
        sys_rst = 1'b1;
        #1;
        checkOutput("rst_out_valid", longint'(bus.out_valid), 0);
        checkOutput("rst_out_data", longint'(bus.out_data), 0);
        checkOutput("rst_in_ready", longint'(bus.in_ready), 1);
        checkOutput("rst_busy", longint'(bus.busy), 0);
        for (int i = 0; i < TAPS; i++) coef_m[i] = 0;
        clearHistory();
        exp_q      = {};
        expc_q     = {};
        trig_c     = -1000;
        dec_m      = 0;
        last_out_m = 0;
        @(posedge sys_clk);
        cyc++;
        #1;
        sys_rst = 1'b0;
    endtask

    // Output monitor: every strobe must match the model, with fixed latency.
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_out_valid", 1, 0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    mon_c   = expc_q.pop_front();
                    checkOutput("out_data", longint'(bus.out_data), mon_exp);
                    checkOutput("latency", longint'(cyc - mon_c), TAPS);
                    last_out_m = mon_exp;
                end
            end else begin
                checkOutput("out_data_hold", longint'(bus.out_data), last_out_m);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.coef_we    = 1'b0;
        bus.coef_addr  = '0;
        bus.coef_wdata = '0;
        bus.clear      = 1'b0;
        doReset();

        // Impulse response through coefficients k+1 (4096 is unity at SHIFT 12).
        for (int i = 0; i < TAPS; i++) writeCoef(i, i + 1);
        sendSample(4096, 1'b0, 0, 0);
        for (int i = 0; i < TAPS * DECIM; i++) sendSample(0, 1'b0, 0, 0);

        // Random coefficients and samples, same-cycle writes and writes during MAC.
        for (int i = 0; i < TAPS; i++) writeCoef(i, longint'($urandom_range(0, 6000)) - 3000);
        for (int n = 0; n < 60; n++) begin
            sendSample(randData(), ($urandom_range(0, 7) == 0), $urandom_range(0, TAPS - 1),
                       longint'($urandom_range(0, 6000)) - 3000);
            if ($urandom_range(0, 3) == 0)
                writeCoef($urandom_range(0, TAPS - 1), longint'($urandom_range(0, 65535)) - 32768);
            idleCycles($urandom_range(0, 2));
        end

        // Saturation at both rails.
        for (int i = 0; i < TAPS; i++) writeCoef(i, 32767);
        for (int n = 0; n < TAPS * DECIM; n++) sendSample(32767, 1'b0, 0, 0);
        checkOutput("sat_high", longint'(bus.out_data), 32767);
        for (int n = 0; n < TAPS * DECIM; n++) sendSample(-32768, 1'b0, 0, 0);
        checkOutput("sat_low", longint'(bus.out_data), -32768);

        // Clear three cycles into a run: no strobe, out_data held, no residue.
        for (int i = 0; i < TAPS; i++) writeCoef(i, i + 1);
        applyStimulus(1'b0, 0, 1'b0, 0, 0, 1'b1, acc_flag);
        for (int n = 0; n < DECIM; n++) sendSample(randData(), 1'b0, 0, 0);
        idleCycles(2);
        applyStimulus(1'b1, 12345, 1'b0, 0, 0, 1'b1, acc_flag);
        idleCycles(TAPS + 4);
        checkOutput("clear_hold", longint'(bus.out_data), -32768);
        sendSample(4096, 1'b0, 0, 0);
        for (int i = 0; i < TAPS * DECIM - 1; i++) sendSample(0, 1'b0, 0, 0);

        // Reset mid-run with a coefficient write attempted during MAC.
        applyStimulus(1'b0, 0, 1'b0, 0, 0, 1'b1, acc_flag);
        for (int n = 0; n < DECIM; n++) sendSample(randData(), 1'b0, 0, 0);
        idleCycles(1);
        writeCoef(3, 999);
        doReset();
        for (int n = 0; n < 2 * DECIM; n++) sendSample(randData(), 1'b0, 0, 0);
        idleCycles(TAPS + 3);
        checkOutput("post_reset_zero", longint'(bus.out_data), 0);

        // Fresh coefficients after reset, more random traffic.
        for (int i = 0; i < TAPS; i++) writeCoef(i, longint'($urandom_range(0, 4000)) - 2000);
        for (int n = 0; n < 30; n++) sendSample(randData(), 1'b0, 0, 0);

        idleCycles(TAPS + 4);
        checkOutput("pending_outputs", longint'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
